// File: rtl/cdc_handshake_rx_if.sv
// Handshake/bus bundle between a toggle-CDC source synchronizer and cdc_handshake_rx.
// master = upstream/downstream environment side, slave = the receive controller.
interface cdc_handshake_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req_tog_sync;
  logic [DATA_WIDTH-1:0] data_sync;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  ack_tog;
  logic                  busy;
  logic                  overrun;

  modport master (
    output req_tog_sync, data_sync, out_ready,
    input  out_data, out_valid, ack_tog, busy, overrun
  );

  modport slave (
    input  req_tog_sync, data_sync, out_ready,
    output out_data, out_valid, ack_tog, busy, overrun
  );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination-side controller for a toggle-handshake CDC: detect toggle, settle, present, ack.
// Optional sticky protocol-violation flag enabled by defining CDC_HS_RX_OVERRUN_EN.
module cdc_handshake_rx #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cdc_handshake_rx_if.slave  hs
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("cdc_handshake_rx: SETTLE_CYCLES must be >= 1");
  end

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  req_prev_q, req_prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ack_tog_q, ack_tog_d;
  logic                  busy_q;
  logic                  req_edge;

  // A level difference against the last serviced level is a new request.
  assign req_edge = hs.req_tog_sync ^ req_prev_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    req_prev_d  = req_prev_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ack_tog_d   = ack_tog_q;

    unique case (state_q)
      IDLE: begin
        if (req_edge) begin
          req_prev_d = hs.req_tog_sync;
          cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_data_d  = hs.data_sync;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q && hs.out_ready) begin
          out_valid_d = 1'b0;
          ack_tog_d   = ~ack_tog_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking assignments.
    if (!rst_n) begin
      state_q     <= IDLE;
      req_prev_q  <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ack_tog_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_prev_q  <= req_prev_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ack_tog_q   <= ack_tog_d;
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef CDC_HS_RX_OVERRUN_EN
  logic overrun_q;

  // A toggle while a word is in flight means the source broke the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if ((state_q != IDLE) && req_edge) begin
      overrun_q <= 1'b1;
    end
  end

  assign hs.overrun = overrun_q;
`else
  assign hs.overrun = 1'b0;
`endif

  assign hs.out_data  = out_data_q;
  assign hs.out_valid = out_valid_q;
  assign hs.ack_tog   = ack_tog_q;
  assign hs.busy      = busy_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed self-checking bench for cdc_handshake_rx (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cdc_handshake_rx;
  localparam int DW = 8;
  localparam int SC = 2;

`ifdef CDC_HS_RX_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cdc_handshake_rx_if #(.DATA_WIDTH(DW)) hs ();

  cdc_handshake_rx #(
    .DATA_WIDTH   (DW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hs   (hs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   flips;
    logic exp_ack;

    hs.req_tog_sync = 1'b0;
    hs.data_sync    = '0;
    hs.out_ready    = 1'b0;
    rst_n           = 1'b0;

    // Reset held for three cycles.
    cyc(3);
    check("rst_valid",   hs.out_valid, 0);
    check("rst_data",    hs.out_data,  0);
    check("rst_ack",     hs.ack_tog,   0);
    check("rst_busy",    hs.busy,      0);
    check("rst_overrun", hs.overrun,   0);
    rst_n = 1'b1;
    cyc(2);

    // Single transfer, ready held high: valid only in cycle 3.
    hs.data_sync    = 8'hA5;
    hs.out_ready    = 1'b1;
    hs.req_tog_sync = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc(1);
      check($sformatf("single_valid_c%0d", c), hs.out_valid, (c == 3) ? 1 : 0);
      check($sformatf("single_busy_c%0d", c),  hs.busy,      (c <= 3) ? 1 : 0);
      check($sformatf("single_ack_c%0d", c),   hs.ack_tog,   (c >= 4) ? 1 : 0);
      if (c == 3) check("single_data", hs.out_data, 32'hA5);
    end

    // Backpressure: ready low until cycle 10, accept in cycle 10.
    hs.out_ready    = 1'b0;
    hs.req_tog_sync = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      check($sformatf("bp_valid_c%0d", c), hs.out_valid, (c >= 3 && c <= 10) ? 1 : 0);
      check($sformatf("bp_ack_c%0d", c),   hs.ack_tog,   (c >= 11) ? 0 : 1);
      if (c >= 3 && c <= 10) check($sformatf("bp_data_c%0d", c), hs.out_data, 32'hA5);
      if (c == 10) hs.out_ready = 1'b1;
      if (c == 11) hs.out_ready = 1'b0;
    end

    // Reset while holding a word: word dropped, no ack, nothing afterwards.
    hs.data_sync    = 8'h3C;
    hs.req_tog_sync = 1'b1;
    cyc(3);
    check("rsthold_valid_pre", hs.out_valid, 1);
    rst_n           = 1'b0;
    hs.req_tog_sync = 1'b0;
    cyc(1);
    check("rsthold_valid", hs.out_valid, 0);
    check("rsthold_ack",   hs.ack_tog,   0);
    check("rsthold_busy",  hs.busy,      0);
    cyc(1);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc(1);
      check($sformatf("rsthold_quiet_c%0d", c), hs.out_valid, 0);
    end

    // Back-to-back: source toggles as soon as it sees the ack flip.
    hs.out_ready = 1'b1;
    exp_ack      = 1'b0;
    flips        = 0;
    for (int w = 1; w <= 4; w++) begin
      hs.data_sync    = DW'(w);
      hs.req_tog_sync = ~hs.req_tog_sync;
      lat = 0;
      do begin
        cyc(1);
        lat++;
      end while (!hs.out_valid && lat < 20);
      check($sformatf("b2b_lat_w%0d", w),  lat,         3);
      check($sformatf("b2b_data_w%0d", w), hs.out_data, w);
      cyc(1);
      exp_ack = ~exp_ack;
      check($sformatf("b2b_ack_w%0d", w), hs.ack_tog, exp_ack);
      if (hs.ack_tog === exp_ack) flips++;
    end
    check("b2b_flips",   flips,      4);
    check("b2b_overrun", hs.overrun, 0);

    // Toggle during HOLD: overrun (when enabled), pending request serviced after accept.
    hs.out_ready    = 1'b0;
    hs.data_sync    = 8'h11;
    hs.req_tog_sync = 1'b1;
    cyc(3);
    check("ovr_valid_c3", hs.out_valid, 1);
    check("ovr_data_c3",  hs.out_data,  32'h11);
    hs.data_sync    = 8'h22;
    hs.req_tog_sync = 1'b0;
    cyc(1);
    check("ovr_flag_c4", hs.overrun,  OVR_EXP);
    check("ovr_data_c4", hs.out_data, 32'h11);
    cyc(1);
    check("ovr_valid_c5", hs.out_valid, 1);
    hs.out_ready = 1'b1;
    cyc(1);
    check("ovr_valid_c6", hs.out_valid, 0);
    check("ovr_busy_c6",  hs.busy,      0);
    check("ovr_ack_c6",   hs.ack_tog,   1);
    cyc(1);
    check("ovr_valid_c7", hs.out_valid, 0);
    cyc(1);
    check("ovr_valid_c8", hs.out_valid, 0);
    cyc(1);
    check("ovr_valid_c9", hs.out_valid, 1);
    check("ovr_data_c9",  hs.out_data,  32'h22);
    cyc(1);
    check("ovr_valid_c10", hs.out_valid, 0);
    check("ovr_ack_c10",   hs.ack_tog,   0);
    check("ovr_flag_end",  hs.overrun,   OVR_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
